hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit.
//  - Load-use hazard: detects loads that forwarding cannot cover.
//  - Multi-cycle MUL/DIV: tracks HI/LO occupancy.
//  - Control-flow kills: branches and exceptions.
//  - Drives stall (IF/PC, IF/ID hold), bubble (NOP into ID/EX) and per-stage flushes.
// PARAMETERS
//  REG_W    5   register index width
//  DIV_LAT  33  cycles a divide occupies HI/LO (>=1)
//  MUL_LAT  2   cycles a multiply occupies HI/LO (>=1)
//  CNT_W    6   busy-counter width; must hold max(DIV_LAT,MUL_LAT)-1
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      async reset, active low
//  id_rs          in   REG_W  rs of instruction in ID
//  id_rt          in   REG_W  rt of instruction in ID
//  id_use_rs      in   1      ID instruction reads rs
//  id_use_rt      in   1      ID instruction reads rt
//  id_md_use      in   1      ID instr reads HI/LO or is MUL/DIV/MTHI/MTLO
//  ex_dst         in   REG_W  destination reg of instruction in EX
//  ex_rfwr        in   1      EX instruction writes RF
//  ex_memrd       in   1      EX instruction is a load
//  ex_md_start    in   1      MUL/DIV issues in EX this cycle
//  ex_md_is_div   in   1      with ex_md_start: 1=divide, 0=multiply
//  ex_branch_taken in  1      branch/jump in EX redirects PC
//  exc_flush      in   1      exception committed at MEM
//  if_stall       out  1      hold PC and IF/ID
//  ex_bubble      out  1      load NOP into ID/EX
//  id_flush       out  1      clear IF/ID
//  ex_flush       out  1      clear ID/EX
//  mem_flush      out  1      clear EX/MEM
//  md_busy        out  1      MUL/DIV in progress (registered)
//  md_done        out  1      one-cycle pulse, HI/LO valid (registered)
// BEHAVIOUR
//  Hazard terms (combinational):
//  - lu_hz = ex_memrd & ex_rfwr & ex_dst!=0 & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt))
//  - md_hz = md_busy & id_md_use
//  - stall = (lu_hz | md_hz) & ~ex_branch_taken & ~exc_flush
//  Outputs:
//  - if_stall = ex_bubble = stall
//  - id_flush = ex_branch_taken | exc_flush
//  - ex_flush = mem_flush = exc_flush
//  - Branch kills the wrong-path ID instruction, so any stall is dropped; exception overrides all.
//  MD FSM (IDLE, BUSY; 1 state bit + CNT_W counter):
//  - IDLE & ex_md_start & ~exc_flush -> BUSY, cnt = (is_div ? DIV_LAT : MUL_LAT) - 1.
//  - BUSY & cnt!=0 -> cnt-1.
//  - BUSY & cnt==0 -> IDLE; md_done=1 next cycle only.
//  - Start sampled at edge t: md_busy high t+1..t+LAT; md_done high for cycle t+LAT+1 only.
//  - Boundary cases:
//    - ex_md_start while BUSY cannot occur legally (md_hz blocks); ignored, no restart.
//    - exc_flush suppresses a same-cycle start; an in-flight op (older instr) completes.
//    - ex_branch_taken never affects the FSM.
//  Reset:
//  - rst_n low forces all outputs 0 (combinational outputs gated), FSM IDLE, cnt 0.
//  - Reset mid-operation aborts with no md_done.
// CONFIGURATION
//  STALL_CNT_EN defined:
//  - Adds output stall_cnt [31:0], reset 0.
//  - +1 every cycle if_stall=1; saturates at 32'hFFFF_FFFF.
//  STALL_CNT_EN undefined: port and counter absent; all else identical.
// TESTING
//  1. ex_memrd=1, ex_rfwr=1, ex_dst=8, id_rs=8, id_use_rs=1
//     -> if_stall=ex_bubble=1 that cycle; ex_dst=0 instead -> 0.
//  2. Load-use as (1) plus ex_branch_taken=1 -> if_stall=0, id_flush=1, ex_flush=0.
//  3. ex_md_start=1, is_div=1 at edge t, id_md_use=1 throughout
//     -> md_busy and if_stall high 33 cycles; md_done one pulse at t+34; stall clears at t+34.
//  4. MUL start, MUL_LAT=2 -> md_busy 2 cycles, md_done once;
//     second ex_md_start while busy -> no extension.
//  5. exc_flush with ex_md_start -> id/ex/mem_flush=1, md_busy stays 0.
//     rst_n low mid-divide -> all outputs 0, no md_done after release.
//  6. STALL_CNT_EN: 5 load-use stall cycles -> stall_cnt=5;
//     preset near max -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO hazard stalls, branch/exception flushes.
// Optional STALL_CNT_EN adds a saturating 32-bit stall-cycle counter output (stall_cnt).
module hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int DIV_LAT = 33,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_use,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_rfwr,
  input  logic             ex_memrd,
  input  logic             ex_md_start,
  input  logic             ex_md_is_div,
  input  logic             ex_branch_taken,
  input  logic             exc_flush,
  output logic             if_stall,
  output logic             ex_bubble,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic             md_busy,
  output logic             md_done
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             lu_hz, md_hz, stall;

  // A load result is only available after MEM, so forwarding cannot cover an immediate use.
  always_comb begin
    lu_hz = ex_memrd && ex_rfwr && (ex_dst != '0) &&
            ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt)));
    md_hz = (state_q == MD_BUSY) && id_md_use;
    stall = (lu_hz || md_hz) && !ex_branch_taken && !exc_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      md_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_done <= done_d;
    end
  end

  // A start while busy is ignored; a start alongside an exception belongs to a killed instruction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (ex_md_start && !exc_flush) begin
          state_d = MD_BUSY;
          cnt_d   = ex_md_is_div ? DIV_CNT : MUL_CNT;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = MD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Combinational outputs are gated so that everything reads 0 while reset is held.
  always_comb begin
    if_stall  = 1'b0;
    ex_bubble = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    md_busy   = (state_q == MD_BUSY);
    if (rst_n) begin
      if_stall  = stall;
      ex_bubble = stall;
      id_flush  = ex_branch_taken || exc_flush;
      ex_flush  = exc_flush;
      mem_flush = exc_flush;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (if_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic
// checked against a cycle-indexed reference model of the hazard and MUL/DIV rules.
module tb_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int DIV_LAT = 33;
  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs, id_rt, ex_dst;
  logic             id_use_rs, id_use_rt, id_md_use;
  logic             ex_rfwr, ex_memrd, ex_md_start, ex_md_is_div;
  logic             ex_branch_taken, exc_flush;
  logic             if_stall, ex_bubble, id_flush, ex_flush, mem_flush, md_busy, md_done;
`ifdef STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_W(REG_W), .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_use(id_md_use), .ex_dst(ex_dst), .ex_rfwr(ex_rfwr), .ex_memrd(ex_memrd),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
    .ex_branch_taken(ex_branch_taken), .exc_flush(exc_flush),
    .if_stall(if_stall), .ex_bubble(ex_bubble), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .md_busy(md_busy), .md_done(md_done)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic             rst_n;
    logic [REG_W-1:0] rs, rt, dst;
    logic             use_rs, use_rt, md_use, rfwr, memrd, md_start, is_div, br, exc;
  } stim_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     start_cyc = -1;
  int     start_lat = 0;
  longint stall_model = 0;
  logic   obs_stall, obs_idflush, obs_exflush, obs_memflush, obs_busy, obs_done;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  // An operation started at the end of cycle c occupies HI/LO for cycles c+1..c+lat.
  function automatic logic modelBusy();
    return (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + start_lat);
  endfunction

  function automatic logic modelDone();
    return (start_cyc >= 0) && (cyc == start_cyc + start_lat + 1);
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input stim_t s, output logic stall_e);
    logic lu, busy_e, done_e;
    lu = s.memrd && s.rfwr && (s.dst != 0) &&
         ((s.use_rs && s.dst == s.rs) || (s.use_rt && s.dst == s.rt));
    busy_e  = s.rst_n && modelBusy();
    done_e  = s.rst_n && modelDone();
    stall_e = s.rst_n && (lu || (busy_e && s.md_use)) && !s.br && !s.exc;
    obs_stall = if_stall; obs_idflush = id_flush; obs_exflush = ex_flush;
    obs_memflush = mem_flush; obs_busy = md_busy; obs_done = md_done;
    checkBit("if_stall", if_stall, stall_e);
    checkBit("ex_bubble", ex_bubble, stall_e);
    checkBit("id_flush", id_flush, s.rst_n && (s.br || s.exc));
    checkBit("ex_flush", ex_flush, s.rst_n && s.exc);
    checkBit("mem_flush", mem_flush, s.rst_n && s.exc);
    checkBit("md_busy", md_busy, busy_e);
    checkBit("md_done", md_done, done_e);
`ifdef STALL_CNT_EN
    checks++;
    assert (stall_cnt === 32'(stall_model)) else begin
      errors++;
      $error("[TB] FAIL stall_cnt observed=%0d expected=%0d cycle=%0d", stall_cnt, stall_model, cyc);
    end
`endif
  endtask

  task automatic applyStimulus(input stim_t s);
    logic stall_e;
    @(negedge clk);
    rst_n = s.rst_n; id_rs = s.rs; id_rt = s.rt; ex_dst = s.dst;
    id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_md_use = s.md_use;
    ex_rfwr = s.rfwr; ex_memrd = s.memrd; ex_md_start = s.md_start;
    ex_md_is_div = s.is_div; ex_branch_taken = s.br; exc_flush = s.exc;
    if (!s.rst_n) begin
      start_cyc = -1;
      stall_model = 0;
    end
    #1;
    checkOutput(s, stall_e);
    @(posedge clk);
    if (s.rst_n) begin
      if (stall_e && stall_model < 64'hFFFF_FFFF) stall_model++;
      if (s.md_start && !s.exc && !modelBusy()) begin
        start_cyc = cyc;
        start_lat = s.is_div ? DIV_LAT : MUL_LAT;
      end
    end
    cyc++;
  endtask

  initial begin
    stim_t s;
    int busy_n, stall_n, done_n, done_at;

    // Reset held with hazard-looking inputs: every output must stay low.
    s = idleStim();
    s.rst_n = 1'b0; s.memrd = 1'b1; s.rfwr = 1'b1; s.dst = 5'd8; s.rs = 5'd8;
    s.use_rs = 1'b1; s.br = 1'b1;
    applyStimulus(s);
    s.exc = 1'b1;
    applyStimulus(s);
    checkBit("reset_flush", obs_idflush, 1'b0);

    // Load-use on rs, then with r0, then on rt, then non-load.
    s = idleStim();
    s.memrd = 1'b1; s.rfwr = 1'b1; s.dst = 5'd8; s.rs = 5'd8; s.use_rs = 1'b1;
    applyStimulus(s);
    checkBit("lu_rs_stall", obs_stall, 1'b1);
    s.dst = 5'd0; s.rs = 5'd0;
    applyStimulus(s);
    checkBit("lu_r0_stall", obs_stall, 1'b0);
    s.dst = 5'd9; s.rs = 5'd3; s.rt = 5'd9; s.use_rs = 1'b1; s.use_rt = 1'b1;
    applyStimulus(s);
    checkBit("lu_rt_stall", obs_stall, 1'b1);
    s.memrd = 1'b0;
    applyStimulus(s);
    checkBit("no_load_stall", obs_stall, 1'b0);

    // Branch kills the stalled ID instruction.
    s = idleStim();
    s.memrd = 1'b1; s.rfwr = 1'b1; s.dst = 5'd8; s.rs = 5'd8; s.use_rs = 1'b1; s.br = 1'b1;
    applyStimulus(s);
    checkBit("br_stall", obs_stall, 1'b0);
    checkBit("br_idflush", obs_idflush, 1'b1);
    checkBit("br_exflush", obs_exflush, 1'b0);

    // Divide with a dependent instruction waiting in ID.
    s = idleStim();
    s.md_start = 1'b1; s.is_div = 1'b1; s.md_use = 1'b1;
    applyStimulus(s);
    s.md_start = 1'b0;
    busy_n = 0; stall_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 37; k++) begin
      applyStimulus(s);
      if (obs_busy) busy_n++;
      if (obs_stall) stall_n++;
      if (obs_done) begin done_n++; done_at = k; end
    end
    checkBit("div_busy_len", busy_n == 33, 1'b1);
    checkBit("div_stall_len", stall_n == 33, 1'b1);
    checkBit("div_done_once", done_n == 1, 1'b1);
    checkBit("div_done_time", done_at == 34, 1'b1);

    // Multiply, with an illegal second start while busy that must not extend it.
    s = idleStim();
    s.md_start = 1'b1;
    applyStimulus(s);
    s.is_div = 1'b1;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(s);
      s.md_start = 1'b0;
      if (obs_busy) busy_n++;
      if (obs_done) begin done_n++; done_at = k; end
    end
    checkBit("mul_busy_len", busy_n == 2, 1'b1);
    checkBit("mul_done_once", done_n == 1 && done_at == 3, 1'b1);

    // Exception suppresses a same-cycle start.
    s = idleStim();
    s.md_start = 1'b1; s.is_div = 1'b1; s.exc = 1'b1;
    applyStimulus(s);
    checkBit("exc_memflush", obs_memflush, 1'b1);
    s = idleStim();
    applyStimulus(s);
    checkBit("exc_no_busy", obs_busy, 1'b0);

    // Reset mid-divide aborts without a completion pulse.
    s = idleStim();
    s.md_start = 1'b1; s.is_div = 1'b1;
    applyStimulus(s);
    s.md_start = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(s);
    checkBit("pre_reset_busy", obs_busy, 1'b1);
    s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    checkBit("mid_reset_busy", obs_busy, 1'b0);
    s.rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(s);
      if (obs_done) done_n++;
    end
    checkBit("reset_no_done", done_n == 0, 1'b1);

    // Randomized traffic with a narrow register range so matches are frequent.
    for (int k = 0; k < 1500; k++) begin
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.dst      = 5'($urandom_range(0, 3));
      s.use_rs   = ($urandom_range(0, 1) == 1);
      s.use_rt   = ($urandom_range(0, 1) == 1);
      s.md_use   = ($urandom_range(0, 1) == 1);
      s.rfwr     = ($urandom_range(0, 3) != 0);
      s.memrd    = ($urandom_range(0, 1) == 1);
      s.md_start = ($urandom_range(0, 5) == 0);
      s.is_div   = ($urandom_range(0, 3) == 0);
      s.br       = ($urandom_range(0, 7) == 0);
      s.exc      = ($urandom_range(0, 15) == 0);
      applyStimulus(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
